// File: rtl/ttl_74161_counter.sv
// ttl_74161_counter: 74161-style presettable binary counter with async clear.
// Optional macro TTL_74161_MODULO_EN makes the terminal count MODULUS-1.
// DELAY_RISE/DELAY_FALL belong to timing-annotated simulation models; this RTL is zero-delay.
module ttl_74161_counter #(
    parameter int WIDTH      = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0,
    parameter int MODULUS    = 2**WIDTH
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Load_bar,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);
`ifdef TTL_74161_MODULO_EN
    localparam logic [WIDTH-1:0] TC = WIDTH'(MODULUS - 1);
`else
    localparam logic [WIDTH-1:0] TC = {WIDTH{1'b1}};
`endif

    logic [WIDTH-1:0] q_q = '0;
    logic [WIDTH-1:0] q_d;
    logic             unused_params;

    assign unused_params = ^{32'(DELAY_RISE), 32'(DELAY_FALL), 32'(MODULUS)};

    // Next state: parallel load beats counting, counting needs both enables, else hold.
    // Above a truncated TC the increment still wraps naturally at 2**WIDTH.
    always_comb q_d = !Load_bar ? D : (ENP && ENT) ? ((q_q == TC) ? '0 : q_q + 1'b1) : q_q;

    // Count register; Clear wins over any coincident clock edge.
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) q_q <= '0;
        else       q_q <= q_d;
    end

    assign Q   = q_q;
    assign RCO = ENT && (q_q == TC);
endmodule

// File: tb/tb_ttl_74161_counter.sv
// tb_ttl_74161_counter: directed checks of load, count, enables, clear, cascade and modulo.
module tb_ttl_74161_counter;
`ifdef TTL_74161_MODULO_EN
    localparam bit MOD_EN = 1'b1;
`else
    localparam bit MOD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0, ld_n = 1'b1, enp = 1'b0, ent = 1'b0;
    logic [3:0] d = '0, q;
    logic       rco;

    logic       c_clr = 1'b0, c_ld_n = 1'b1, c_enp = 1'b0, c_ent = 1'b1;
    logic [7:0] c_d = '0;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, hi_rco;

    logic       m_clr = 1'b0, m_ld_n = 1'b1, m_en = 1'b0;
    logic [3:0] m_d = '0, m_q;
    logic       m_rco;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ttl_74161_counter #(.WIDTH(4)) u_dut (
        .Clk(clk), .Clear(clr), .Load_bar(ld_n), .ENP(enp), .ENT(ent), .D(d), .Q(q), .RCO(rco)
    );

    ttl_74161_counter #(.WIDTH(4)) u_lo (
        .Clk(clk), .Clear(c_clr), .Load_bar(c_ld_n), .ENP(c_enp), .ENT(c_ent), .D(c_d[3:0]), .Q(lo_q), .RCO(lo_rco)
    );

    ttl_74161_counter #(.WIDTH(4)) u_hi (
        .Clk(clk), .Clear(c_clr), .Load_bar(c_ld_n), .ENP(c_enp), .ENT(lo_rco), .D(c_d[7:4]), .Q(hi_q), .RCO(hi_rco)
    );

    ttl_74161_counter #(.WIDTH(4), .MODULUS(10)) u_mod (
        .Clk(clk), .Clear(m_clr), .Load_bar(m_ld_n), .ENP(m_en), .ENT(m_en), .D(m_d), .Q(m_q), .RCO(m_rco)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if (q !== 4'h0) begin n_bad++; $display("FAIL power_up q: got %h want 0", q); end
        ld_n = 1'b0; d = 4'hA;
        tick();
        n_cmp++;
        if (q !== 4'hA) begin n_bad++; $display("FAIL reset_preload q: got %h want a", q); end
        #2 clr = 1'b1;
        #1;
        n_cmp++;
        if ({q, rco} !== {4'h0, 1'b0}) begin n_bad++; $display("FAIL async_clear q/rco: got %h/%b want 0/0", q, rco); end
        clr = 1'b0; ld_n = 1'b1; enp = 1'b0; ent = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (q !== 4'h0) begin n_bad++; $display("FAIL hold_enp0[%0d] q: got %h want 0", i, q); end
        end
    endtask

    task automatic test_load_count;
        logic [3:0] exp_q [3] = '{4'hE, 4'hF, 4'h0};
        logic       exp_r [3] = '{1'b0, 1'b1, 1'b0};
        ld_n = 1'b0; d = 4'hD;
        tick();
        n_cmp++;
        if ({q, rco} !== {4'hD, 1'b0}) begin n_bad++; $display("FAIL load_d q/rco: got %h/%b want d/0", q, rco); end
        ld_n = 1'b1; enp = 1'b1; ent = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({q, rco} !== {exp_q[i], exp_r[i]}) begin
                n_bad++; $display("FAIL count[%0d] q/rco: got %h/%b want %h/%b", i, q, rco, exp_q[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_priority;
        ld_n = 1'b0; enp = 1'b0; ent = 1'b0; d = 4'h5;
        tick();
        n_cmp++;
        if (q !== 4'h5) begin n_bad++; $display("FAIL load_no_enable q: got %h want 5", q); end
        ld_n = 1'b1; enp = 1'b1; ent = 1'b0;
        tick();
        n_cmp++;
        if ({q, rco} !== {4'h5, 1'b0}) begin n_bad++; $display("FAIL ent0_hold q/rco: got %h/%b want 5/0", q, rco); end
        enp = 1'b0; ent = 1'b1;
        tick();
        n_cmp++;
        if (q !== 4'h5) begin n_bad++; $display("FAIL enp0_hold q: got %h want 5", q); end
        ld_n = 1'b0; ent = 1'b0; d = 4'hF;
        tick();
        n_cmp++;
        if ({q, rco} !== {4'hF, 1'b0}) begin n_bad++; $display("FAIL tc_ent0 q/rco: got %h/%b want f/0", q, rco); end
        ld_n = 1'b1; ent = 1'b1;
        #1;
        n_cmp++;
        if (rco !== 1'b1) begin n_bad++; $display("FAIL rco_comb_ent rco: got %b want 1", rco); end
        ld_n = 1'b0; enp = 1'b1; ent = 1'b1; d = 4'h3;
        tick();
        n_cmp++;
        if ({q, rco} !== {4'h3, 1'b0}) begin n_bad++; $display("FAIL load_over_count q/rco: got %h/%b want 3/0", q, rco); end
    endtask

    task automatic test_cascade;
        logic [7:0] exp_c [3] = '{8'h0F, 8'h10, 8'h11};
        c_ld_n = 1'b0; c_d = 8'h0E;
        tick();
        n_cmp++;
        if ({hi_q, lo_q} !== 8'h0E) begin n_bad++; $display("FAIL casc_load: got %h want 0e", {hi_q, lo_q}); end
        c_ld_n = 1'b1; c_enp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({hi_q, lo_q, hi_rco} !== {exp_c[i], 1'b0}) begin
                n_bad++; $display("FAIL casc_count[%0d] q/rco: got %h/%b want %h/0", i, {hi_q, lo_q}, hi_rco, exp_c[i]);
            end
        end
        c_ld_n = 1'b0; c_d = 8'hFE;
        tick();
        n_cmp++;
        if ({hi_q, lo_q, hi_rco} !== {8'hFE, 1'b0}) begin n_bad++; $display("FAIL casc_fe q/rco: got %h/%b want fe/0", {hi_q, lo_q}, hi_rco); end
        c_ld_n = 1'b1;
        tick();
        n_cmp++;
        if ({hi_q, lo_q, hi_rco} !== {8'hFF, 1'b1}) begin n_bad++; $display("FAIL casc_ff q/rco: got %h/%b want ff/1", {hi_q, lo_q}, hi_rco); end
        tick();
        n_cmp++;
        if ({hi_q, lo_q, hi_rco} !== {8'h00, 1'b0}) begin n_bad++; $display("FAIL casc_wrap q/rco: got %h/%b want 00/0", {hi_q, lo_q}, hi_rco); end
        c_enp = 1'b0;
    endtask

    task automatic test_async_clear;
        ld_n = 1'b0; enp = 1'b1; ent = 1'b1; d = 4'h6;
        tick();
        ld_n = 1'b1;
        tick();
        n_cmp++;
        if (q !== 4'h7) begin n_bad++; $display("FAIL pre_clear q: got %h want 7", q); end
        @(posedge clk);
        clr = 1'b1;
        #1;
        n_cmp++;
        if ({q, rco} !== {4'h0, 1'b0}) begin n_bad++; $display("FAIL clear_at_edge q/rco: got %h/%b want 0/0", q, rco); end
        @(negedge clk);
        clr = 1'b0;
        tick();
        n_cmp++;
        if (q !== 4'h1) begin n_bad++; $display("FAIL after_clear q: got %h want 1", q); end
    endtask

    task automatic test_modulo;
        logic [3:0] e;
        logic       er;
        m_clr = 1'b1;
        #1 m_clr = 1'b0;
        m_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            e  = MOD_EN ? 4'(i % 10) : 4'(i);
            er = (e == (MOD_EN ? 4'd9 : 4'd15));
            n_cmp++;
            if ({m_q, m_rco} !== {e, er}) begin n_bad++; $display("FAIL mod_count[%0d] q/rco: got %h/%b want %h/%b", i, m_q, m_rco, e, er); end
        end
        m_ld_n = 1'b0; m_d = 4'd12;
        tick();
        m_ld_n = 1'b1;
        for (int i = 13; i <= 16; i++) begin
            tick();
            e  = 4'(i % 16);
            er = !MOD_EN && (e == 4'd15);
            n_cmp++;
            if ({m_q, m_rco} !== {e, er}) begin n_bad++; $display("FAIL mod_over[%0d] q/rco: got %h/%b want %h/%b", i, m_q, m_rco, e, er); end
        end
        m_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_count();
        test_priority();
        test_cascade();
        test_async_clear();
        test_modulo();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
